// File: rtl/tlk2711_pkg.sv
// Shared types and AXI read-address field layout for the tlk2711 PS read-port arbiter.
package tlk2711_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } rd_state_e;

  // Packed AR payload, MSB first: {arid[3:0], araddr, arlen[7:0], arsize[2:0],
  // arburst[1:0], arprot[2:0], arcache[3:0], aruser[0:0]}.
  localparam int AR_ID_W      = 4;
  localparam int AR_FIXED_W   = 21;
  localparam int AR_USER_W    = 1;
  localparam int AR_CACHE_LSB = AR_USER_W;
  localparam int AR_PROT_LSB  = AR_CACHE_LSB + 4;
  localparam int AR_BURST_LSB = AR_PROT_LSB + 3;
  localparam int AR_SIZE_LSB  = AR_BURST_LSB + 2;
  localparam int AR_LEN_LSB   = AR_SIZE_LSB + 3;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  function automatic int ar_width(input int addr_w);
    return AR_ID_W + addr_w + AR_FIXED_W;
  endfunction

endpackage

// File: rtl/tlk2711_rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, registered last-winner memory.
module tlk2711_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_grant;  // 0 = requester 0 won last, 1 = requester 1 won last

  always_comb begin
    // NOTE: default assignment first so every path drives gnt and no latch is inferred.
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;  // requester 0 wins the first tie
    end else if (accept && (gnt != 2'b00)) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/tlk2711_axi_rd_arb.sv
// Shares one PS HP AXI4 read port between the tlk2711a/b DMA read masters,
// one outstanding burst at a time, with length-mismatch and stall detection.
module tlk2711_axi_rd_arb
  import tlk2711_pkg::*;
#(
  parameter int ADDR_WIDTH     = 48,
  parameter int DATA_WIDTH     = 64,
  parameter int AR_W           = ar_width(ADDR_WIDTH),
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  a_arvalid,
  output logic                  a_arready,
  input  logic [AR_W-1:0]       a_ar,
  output logic                  a_rvalid,
  input  logic                  a_rready,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [1:0]            a_rresp,
  output logic                  a_rlast,

  input  logic                  b_arvalid,
  output logic                  b_arready,
  input  logic [AR_W-1:0]       b_ar,
  output logic                  b_rvalid,
  input  logic                  b_rready,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [1:0]            b_rresp,
  output logic                  b_rlast,

  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [AR_W-1:0]       m_ar,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,

  input  logic                  i_err_clr,
  output logic [1:0]            o_grant,
  output logic                  o_len_err,
  output logic                  o_timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  rd_state_e       state;
  logic [7:0]      len_q;
  logic [8:0]      beat_cnt;
  logic [WD_W-1:0] wd_cnt;

  logic [1:0]      gnt;
  logic            idle;
  logic [AR_W-1:0] sel_ar;
  logic            ar_hs;
  logic            r_hs;
  logic            len_err_set;
  logic            wd_fire;

  assign idle = (state == ST_IDLE);

  tlk2711_rr_arb2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    ({b_arvalid, a_arvalid}),
    .accept (idle),
    .gnt    (gnt)
  );

  assign a_arready = idle & gnt[0];
  assign b_arready = idle & gnt[1];
  assign sel_ar    = gnt[1] ? b_ar : a_ar;

  // R channel is a pure combinational route to the burst owner.
  assign a_rvalid = (state == ST_DATA) & o_grant[0] & m_rvalid;
  assign b_rvalid = (state == ST_DATA) & o_grant[1] & m_rvalid;
  assign m_rready = (state == ST_DATA) &
                    ((o_grant[0] & a_rready) | (o_grant[1] & b_rready));
  assign a_rdata  = m_rdata;
  assign b_rdata  = m_rdata;
  assign a_rresp  = m_rresp;
  assign b_rresp  = m_rresp;
  assign a_rlast  = m_rlast;
  assign b_rlast  = m_rlast;

  assign ar_hs = (state == ST_ADDR) & m_arvalid & m_arready;
  assign r_hs  = (state == ST_DATA) & m_rvalid & m_rready;

  // Early rlast, late rlast, or rlast after an overrun all count as a mismatch.
  assign len_err_set = r_hs &
                       (( m_rlast & (beat_cnt != {1'b0, len_q})) |
                        (!m_rlast & (beat_cnt == {1'b0, len_q})));

  assign wd_fire = !idle & !ar_hs & !r_hs &
                   (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      m_arvalid <= 1'b0;
      m_ar      <= '0;
      o_grant   <= 2'b00;
      len_q     <= '0;
      beat_cnt  <= '0;
      wd_cnt    <= '0;
      o_len_err <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
      o_len_err <= len_err_set | (o_len_err & ~i_err_clr);
      o_timeout <= wd_fire | (o_timeout & ~i_err_clr);

      if (idle || ar_hs || r_hs) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          if (gnt != 2'b00) begin
            m_ar      <= sel_ar;
            len_q     <= sel_ar[AR_LEN_LSB +: 8];
            o_grant   <= gnt;
            m_arvalid <= 1'b1;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            beat_cnt  <= '0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (m_rlast) begin
              o_grant <= 2'b00;
              state   <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlk2711_axi_rd_arb.sv
// Directed bench for tlk2711_axi_rd_arb: single burst, round-robin contention,
// backpressure, length errors, watchdog and reset recovery.
module tb_tlk2711_axi_rd_arb;

  localparam int AW   = 48;
  localparam int DW   = 64;
  localparam int ARW  = 4 + AW + 21;
  localparam int TOUT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_arvalid, a_arready, a_rvalid, a_rready, a_rlast;
  logic [ARW-1:0] a_ar;
  logic [DW-1:0] a_rdata;
  logic [1:0]    a_rresp;
  logic          b_arvalid, b_arready, b_rvalid, b_rready, b_rlast;
  logic [ARW-1:0] b_ar;
  logic [DW-1:0] b_rdata;
  logic [1:0]    b_rresp;
  logic          m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [ARW-1:0] m_ar;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          i_err_clr;
  logic [1:0]    o_grant;
  logic          o_len_err, o_timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tlk2711_axi_rd_arb #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .AR_W           (ARW),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_arvalid (a_arvalid),
    .a_arready (a_arready),
    .a_ar      (a_ar),
    .a_rvalid  (a_rvalid),
    .a_rready  (a_rready),
    .a_rdata   (a_rdata),
    .a_rresp   (a_rresp),
    .a_rlast   (a_rlast),
    .b_arvalid (b_arvalid),
    .b_arready (b_arready),
    .b_ar      (b_ar),
    .b_rvalid  (b_rvalid),
    .b_rready  (b_rready),
    .b_rdata   (b_rdata),
    .b_rresp   (b_rresp),
    .b_rlast   (b_rlast),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_ar      (m_ar),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast),
    .i_err_clr (i_err_clr),
    .o_grant   (o_grant),
    .o_len_err (o_len_err),
    .o_timeout (o_timeout)
  );

  function automatic logic [ARW-1:0] make_ar(input logic [3:0] id, input logic [AW-1:0] addr,
                                             input logic [7:0] len);
    return {id, addr, len, 3'd3, 2'b01, 3'b000, 4'b0011, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the requests already driven.
  task automatic issue(input logic [1:0] exp_g, input string tag);
    #1;
    check({tag, "_arready"}, {b_arready, a_arready}, exp_g);
    @(posedge clk);
    @(negedge clk);
    if (exp_g[0]) a_arvalid = 1'b0;
    if (exp_g[1]) b_arvalid = 1'b0;
    check({tag, "_grant"}, o_grant, exp_g);
    check({tag, "_m_arvalid"}, m_arvalid, 1'b1);
  endtask

  task automatic addr_phase(input int stall, input logic [ARW-1:0] exp_ar, input string tag);
    for (int i = 0; i < stall; i++) begin
      check({tag, "_m_ar_stall"}, m_ar, exp_ar);
      check({tag, "_m_arvalid_stall"}, m_arvalid, 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    m_arready = 1'b1;
    check({tag, "_m_ar"}, m_ar, exp_ar);
    @(posedge clk);
    @(negedge clk);
    m_arready = 1'b0;
    check({tag, "_m_arvalid_done"}, m_arvalid, 1'b0);
  endtask

  task automatic data_phase(input logic [1:0] owner, input int nbeats, input logic [DW-1:0] base,
                            input string tag);
    for (int i = 0; i < nbeats; i++) begin
      m_rvalid = 1'b1;
      m_rdata  = base + DW'(i);
      m_rresp  = 2'b00;
      m_rlast  = (i == nbeats - 1);
      a_rready = 1'b1;
      b_rready = 1'b1;
      #1;
      check({tag, "_rvalid_route"}, {b_rvalid, a_rvalid}, owner);
      check({tag, "_m_rready"}, m_rready, 1'b1);
      check({tag, "_rdata"}, owner[1] ? b_rdata : a_rdata, base + DW'(i));
      @(posedge clk);
      @(negedge clk);
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [ARW-1:0] pa, pb, pw;
    int idx;
    int stall;

    rst = 1'b1;
    a_arvalid = 0; a_ar = '0; a_rready = 0;
    b_arvalid = 0; b_ar = '0; b_rready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = 0; m_rlast = 0;
    i_err_clr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state; R valid from the PS must not leak out while idle.
    m_rvalid = 1'b1;
    #1;
    check("rst_grant", o_grant, 2'b00);
    check("rst_m_arvalid", m_arvalid, 1'b0);
    check("rst_m_ar", m_ar, '0);
    check("rst_flags", {o_len_err, o_timeout}, 2'b00);
    check("rst_arready", {b_arready, a_arready}, 2'b00);
    check("rst_rvalid", {b_rvalid, a_rvalid}, 2'b00);
    check("rst_m_rready", m_rready, 1'b0);
    m_rvalid = 1'b0;

    // Single request from a, arlen = 3.
    pa = make_ar(4'h5, 48'h0000_1234_5000, 8'd3);
    a_ar = pa;
    a_arvalid = 1'b1;
    issue(2'b01, "single");
    check("single_b_arready_busy", b_arready, 1'b0);
    addr_phase(0, pa, "single");
    data_phase(2'b01, 4, 64'hA5A5_0000_0000_0010, "single");
    check("single_grant_end", o_grant, 2'b00);
    check("single_len_err", o_len_err, 1'b0);

    // Contention from reset: alternation a,b,a,b,a,b.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    a_ar = make_ar(4'h1, 48'h0000_0000_A000, 8'd0);
    b_ar = make_ar(4'h2, 48'h0000_0000_B000, 8'd0);
    for (int k = 0; k < 6; k++) begin
      logic [1:0] exp_g;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      a_arvalid = 1'b1;
      b_arvalid = 1'b1;
      issue(exp_g, "rr");
      addr_phase(0, exp_g[0] ? a_ar : b_ar, "rr");
      data_phase(exp_g, 1, 64'h100 * DW'(k), "rr");
      check("rr_grant_end", o_grant, 2'b00);
    end
    a_arvalid = 1'b0;
    b_arvalid = 1'b0;

    // Backpressure: AR stall for 10 cycles, then random rready stalls on a.
    pb = make_ar(4'h7, 48'h0000_0BAD_C000, 8'd3);
    a_ar = pb;
    a_arvalid = 1'b1;
    issue(2'b01, "bp");
    addr_phase(10, pb, "bp");
    idx = 0;
    stall = 0;
    for (int cyc = 0; cyc < 100 && idx < 4; cyc++) begin
      m_rvalid = 1'b1;
      m_rdata  = 64'hB000 + DW'(idx);
      m_rlast  = (idx == 3);
      a_rready = (stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      check("bp_m_rready_mirror", m_rready, a_rready);
      check("bp_a_rvalid", a_rvalid, 1'b1);
      if (a_rready) begin
        check("bp_rdata_order", a_rdata, 64'hB000 + DW'(idx));
        idx++;
        stall = 0;
      end else begin
        stall++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    check("bp_beats_delivered", idx, 4);
    check("bp_grant_end", o_grant, 2'b00);
    check("bp_no_timeout", o_timeout, 1'b0);

    // Length error: arlen = 3, rlast on beat 2.
    a_ar = make_ar(4'h3, 48'h0000_0000_C000, 8'd3);
    a_arvalid = 1'b1;
    issue(2'b01, "lerr");
    addr_phase(0, a_ar, "lerr");
    data_phase(2'b01, 2, 64'hC0, "lerr");
    check("lerr_flag", o_len_err, 1'b1);
    check("lerr_grant_idle", o_grant, 2'b00);
    a_arvalid = 1'b1;
    #1;
    check("lerr_idle_arready", a_arready, 1'b1);
    a_arvalid = 1'b0;
    i_err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_err_clr = 1'b0;
    check("lerr_cleared", o_len_err, 1'b0);

    // Overrun: arlen = 0 but first beat lacks rlast; set beats a coincident clear.
    a_ar = make_ar(4'h4, 48'h0000_0000_D000, 8'd0);
    a_arvalid = 1'b1;
    issue(2'b01, "ovr");
    addr_phase(0, a_ar, "ovr");
    m_rvalid = 1'b1;
    m_rlast  = 1'b0;
    m_rdata  = 64'hD0;
    a_rready = 1'b1;
    i_err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_err_clr = 1'b0;
    check("ovr_set_wins", o_len_err, 1'b1);
    check("ovr_still_routing", o_grant, 2'b01);
    data_phase(2'b01, 1, 64'hD1, "ovr");
    check("ovr_grant_end", o_grant, 2'b00);
    i_err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_err_clr = 1'b0;
    check("ovr_cleared", o_len_err, 1'b0);

    // Watchdog: PS never accepts the address.
    pw = make_ar(4'h9, 48'h0000_0000_E000, 8'd7);
    a_ar = pw;
    a_arvalid = 1'b1;
    issue(2'b01, "wd");
    check("wd_start", o_timeout, 1'b0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("wd_before_limit", o_timeout, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("wd_at_limit", o_timeout, 1'b1);
    check("wd_no_abort", {m_arvalid, o_grant}, 3'b101);

    // Reset recovers the hung transaction.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_rvalid = 1'b1;
    #1;
    check("rrst_grant", o_grant, 2'b00);
    check("rrst_m_arvalid", m_arvalid, 1'b0);
    check("rrst_m_ar", m_ar, '0);
    check("rrst_flags", {o_len_err, o_timeout}, 2'b00);
    check("rrst_rvalid", {b_rvalid, a_rvalid}, 2'b00);
    m_rvalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
